// File: rtl/commit_arbiter.sv
// commit_arbiter: commit stage behind the execution units.
// Collects finished results over each unit's req/clear handshake, arbitrates
// round-robin, drives the single register-file write port, pulses a
// per-commit completion for the scoreboard, reports execution errors and
// halts commit until flushed.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   u_res, u_rd               packed per-unit result data / destination reg
//   u_valid, u_error, u_req   per-unit result valid, error flag, commit request
//   u_clear                   one-cycle acknowledge to the granted unit
//   stall                     register-file port busy, no grant this cycle
//   flush                     leave HALT
//   rf_we, rf_waddr, rf_wdata register-file write port
//   cm_valid, cm_rd, cm_unit  retired commit (scoreboard release)
//   exc_valid, exc_unit       error commit pulse and its source unit
//   halted                    arbiter is in HALT
module commit_arbiter #(
  parameter int unsigned NUM_UNITS  = 4,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned UIDX_W     = $clog2(NUM_UNITS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_UNITS*XLEN-1:0]      u_res,
  input  logic [NUM_UNITS*REG_ADDR_W-1:0] u_rd,
  input  logic [NUM_UNITS-1:0]           u_valid,
  input  logic [NUM_UNITS-1:0]           u_error,
  input  logic [NUM_UNITS-1:0]           u_req,
  output logic [NUM_UNITS-1:0]           u_clear,
  input  logic                           stall,
  input  logic                           flush,
  output logic                           rf_we,
  output logic [REG_ADDR_W-1:0]          rf_waddr,
  output logic [XLEN-1:0]                rf_wdata,
  output logic                           cm_valid,
  output logic [REG_ADDR_W-1:0]          cm_rd,
  output logic [UIDX_W-1:0]              cm_unit,
  output logic                           exc_valid,
  output logic [UIDX_W-1:0]              exc_unit,
  output logic                           halted
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]            state, state_nxt;
  logic [UIDX_W-1:0]     ptr, ptr_nxt;
  logic [XLEN-1:0]       res_a [NUM_UNITS];
  logic [REG_ADDR_W-1:0] rd_a  [NUM_UNITS];
  logic [NUM_UNITS-1:0]  elig;
  logic                  found;
  logic [UIDX_W-1:0]     gnt;
  int unsigned           cand;
  logic                  do_grant;

  logic [NUM_UNITS-1:0]  clear_nxt;
  logic                  rf_we_nxt, cm_valid_nxt, exc_valid_nxt;
  logic [REG_ADDR_W-1:0] rf_waddr_nxt, cm_rd_nxt;
  logic [XLEN-1:0]       rf_wdata_nxt;
  logic [UIDX_W-1:0]     cm_unit_nxt, exc_unit_nxt;

  // Unpack per-unit payloads.
  always_comb begin
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      res_a[i] = u_res[i*XLEN +: XLEN];
      rd_a[i]  = u_rd[i*REG_ADDR_W +: REG_ADDR_W];
    end
  end

  // A unit still holding req in its acknowledge cycle must not be granted again.
  assign elig = u_req & u_valid & ~u_clear;

  // Round-robin pick: first eligible unit at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    cand  = 0;
    for (int unsigned k = 0; k < NUM_UNITS; k++) begin
      cand = (32'(ptr) + k) % NUM_UNITS;
      if (!found && elig[UIDX_W'(cand)]) begin
        found = 1'b1;
        gnt   = UIDX_W'(cand);
      end
    end
  end

  // Next state, pointer and registered-output values.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    clear_nxt     = '0;
    rf_we_nxt     = 1'b0;
    rf_waddr_nxt  = '0;
    rf_wdata_nxt  = '0;
    cm_valid_nxt  = 1'b0;
    cm_rd_nxt     = '0;
    cm_unit_nxt   = '0;
    exc_valid_nxt = 1'b0;
    exc_unit_nxt  = '0;
    do_grant      = (state == ST_RUN) && !stall && found;

    if (state == ST_HALT && flush) begin
      state_nxt = ST_RUN;
    end

    if (do_grant) begin
      ptr_nxt      = UIDX_W'((32'(gnt) + 32'd1) % NUM_UNITS);
      clear_nxt    = NUM_UNITS'(1'b1) << gnt;
      cm_valid_nxt = 1'b1;
      cm_rd_nxt    = rd_a[gnt];
      cm_unit_nxt  = gnt;
      if (u_error[gnt]) begin
        exc_valid_nxt = 1'b1;
        exc_unit_nxt  = gnt;
        state_nxt     = ST_HALT;
      end else if (rd_a[gnt] != '0) begin
        // rd=0 retires and clears but never writes.
        rf_we_nxt    = 1'b1;
        rf_waddr_nxt = rd_a[gnt];
        rf_wdata_nxt = res_a[gnt];
      end
    end
  end

  // State and output registers; reset overrides any pending grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      ptr       <= '0;
      u_clear   <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      cm_valid  <= 1'b0;
      cm_rd     <= '0;
      cm_unit   <= '0;
      exc_valid <= 1'b0;
      exc_unit  <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      u_clear   <= clear_nxt;
      rf_we     <= rf_we_nxt;
      rf_waddr  <= rf_waddr_nxt;
      rf_wdata  <= rf_wdata_nxt;
      cm_valid  <= cm_valid_nxt;
      cm_rd     <= cm_rd_nxt;
      cm_unit   <= cm_unit_nxt;
      exc_valid <= exc_valid_nxt;
      exc_unit  <= exc_unit_nxt;
    end
  end

  assign halted = (state == ST_HALT);

endmodule
